// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-RAM port-2 arbiter.
package dmem_arbiter_pkg;

    typedef enum logic {
        CPU_PRI   = 1'b0,
        DMA_BURST = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    localparam int unsigned DEF_STARVE_LIMIT = 4;
    localparam int unsigned DEF_MAX_BURST    = 4;

endpackage

// File: rtl/dmem_rd_return.sv
// One-stage read-owner register steering synchronous RAM read data back to its issuer.
module dmem_rd_return
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gnt,
    input  owner_t            owner,
    input  logic              we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata
);

    logic   rd_pending;
    owner_t rd_owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pending <= 1'b0;
            rd_owner   <= OWN_CPU;
        end else begin
            rd_pending <= gnt & ~we;
            rd_owner   <= owner;
        end
    end

    // Gating with rst drops a response whose reset arrives in its return cycle.
    always_comb begin
        cpu_rvalid = rd_pending & ~rst & (rd_owner == OWN_CPU);
        dma_rvalid = rd_pending & ~rst & (rd_owner == OWN_DMA);
        cpu_rdata  = cpu_rvalid ? ram_rdata : '0;
        dma_rdata  = dma_rvalid ? ram_rdata : '0;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// CPU-priority arbiter for the data RAM port with starvation-forced, bounded DMA bursts.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 11,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int unsigned MAX_BURST    = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_last,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [BW-1:0] BEAT_LAST  = BW'(MAX_BURST - 1);

    arb_state_t    state, state_next;
    logic [SW-1:0] starve_cnt, starve_next;
    logic [BW-1:0] beat_cnt, beat_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CPU_PRI;
            starve_cnt <= '0;
            beat_cnt   <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
            beat_cnt   <= beat_next;
        end
    end

    always_comb begin
        state_next = state;
        beat_next  = beat_cnt;
        cpu_gnt    = 1'b0;
        dma_gnt    = 1'b0;
        if (!rst) begin
            unique case (state)
                CPU_PRI: begin
                    if (starve_cnt == STARVE_MAX && dma_req) begin
                        dma_gnt = 1'b1;
                        if (!dma_last && MAX_BURST > 1) begin
                            state_next = DMA_BURST;
                            beat_next  = BW'(1);
                        end
                    end else if (cpu_req) begin
                        cpu_gnt = 1'b1;
                    end else if (dma_req) begin
                        dma_gnt = 1'b1;
                    end
                end
                DMA_BURST: begin
                    // beat_cnt holds beats already granted, so BEAT_LAST means this is beat MAX_BURST.
                    if (dma_req) begin
                        dma_gnt = 1'b1;
                        if (dma_last || beat_cnt == BEAT_LAST) begin
                            state_next = CPU_PRI;
                            beat_next  = '0;
                        end else begin
                            beat_next = beat_cnt + BW'(1);
                        end
                    end else begin
                        cpu_gnt    = cpu_req;
                        state_next = CPU_PRI;
                        beat_next  = '0;
                    end
                end
                default: begin
                    state_next = CPU_PRI;
                    beat_next  = '0;
                end
            endcase
        end
    end

    always_comb begin
        starve_next = starve_cnt;
        if (dma_gnt) begin
            starve_next = '0;
        end else if (dma_req && starve_cnt != STARVE_MAX) begin
            starve_next = starve_cnt + SW'(1);
        end
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (dma_gnt) begin
            ram_we    = dma_we;
            ram_addr  = dma_addr;
            ram_wdata = dma_wdata;
        end else if (cpu_gnt) begin
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;

    dmem_rd_return #(
        .DATA_W(DATA_W)
    ) u_rd_return (
        .clk       (clk),
        .rst       (rst),
        .gnt       (cpu_gnt | dma_gnt),
        .owner     (dma_gnt ? OWN_DMA : OWN_CPU),
        .we        (ram_we),
        .ram_rdata (ram_rdata),
        .cpu_rvalid(cpu_rvalid),
        .cpu_rdata (cpu_rdata),
        .dma_rvalid(dma_rvalid),
        .dma_rdata (dma_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a rule-level model.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int AW = 11;
    localparam int DW = 32;
    localparam int SL = 4;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dma_req, dma_we, dma_last, dma_gnt, dma_rvalid;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata, ram_rdata;

    int vectors = 0;
    int miscompares = 0;

    dmem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_last(dma_last), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with a bench-side preload port.
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    logic [DW-1:0] mem [0:2047];

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Reference model: winner 0=none, 1=cpu, 2=dma; rv_owner uses the same coding.
    int            m_starve = 0;
    int            m_beats  = 0;
    bit            m_burst  = 1'b0;
    int            m_rv_owner = 0;
    logic [DW-1:0] m_rv_data = '0;
    logic [DW-1:0] exp_mem [0:2047];
    logic [DW-1:0] init_data [0:15];

    function automatic int exp_winner();
        if (rst) return 0;
        if (m_burst) return dma_req ? 2 : (cpu_req ? 1 : 0);
        if (m_starve == SL && dma_req) return 2;
        if (cpu_req) return 1;
        if (dma_req) return 2;
        return 0;
    endfunction

    always @(posedge clk) begin : model_upd
        int w;
        w = exp_winner();
        if (pl_en) exp_mem[pl_addr] <= pl_data;
        if (rst) begin
            m_starve <= 0; m_burst <= 1'b0; m_beats <= 0; m_rv_owner <= 0;
        end else begin
            if (w == 2) m_starve <= 0;
            else if (dma_req && m_starve < SL) m_starve <= m_starve + 1;
            if (m_burst) begin
                if (dma_req && !dma_last && m_beats + 1 < MB) m_beats <= m_beats + 1;
                else begin m_burst <= 1'b0; m_beats <= 0; end
            end else if (w == 2 && m_starve == SL && !dma_last && MB > 1) begin
                m_burst <= 1'b1; m_beats <= 1;
            end
            m_rv_owner <= 0;
            if (w == 1) begin
                if (cpu_we) exp_mem[cpu_addr] <= cpu_wdata;
                else begin m_rv_owner <= 1; m_rv_data <= exp_mem[cpu_addr]; end
            end else if (w == 2) begin
                if (dma_we) exp_mem[dma_addr] <= dma_wdata;
                else begin m_rv_owner <= 2; m_rv_data <= exp_mem[dma_addr]; end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0; dma_last = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        next_cycle();
        next_cycle();
        rst = 0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1; pl_addr = a; pl_data = d;
        next_cycle();
        pl_en = 0;
    endtask

    task automatic test_reset();
        rst = 1; cpu_req = 1; dma_req = 1;
        #1;
        vectors++;
        if (cpu_gnt !== 1'b0 || dma_gnt !== 1'b0 || ram_we !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_gnt: cpu_gnt=%b dma_gnt=%b ram_we=%b expected 0 0 0", cpu_gnt, dma_gnt, ram_we);
        end
        vectors++;
        if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0 || cpu_rdata !== '0 || dma_rdata !== '0) begin
            miscompares++;
            $display("FAIL reset_rd: rvalid %b/%b rdata %h/%h expected all zero", cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata);
        end
        do_reset();
        vectors++;
        if (dut.state !== CPU_PRI || dut.starve_cnt !== '0 || dut.beat_cnt !== '0) begin
            miscompares++;
            $display("FAIL reset_state: state=%0d starve=%0d beat=%0d expected 0 0 0", dut.state, dut.starve_cnt, dut.beat_cnt);
        end
    endtask

    task automatic test_cpu_read();
        do_reset();
        preload(11'h010, 32'hDEADBEEF);
        cpu_req = 1; cpu_we = 0; cpu_addr = 11'h010;
        #1;
        vectors++;
        if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0 || ram_addr !== 11'h010 || ram_we !== 1'b0) begin
            miscompares++;
            $display("FAIL cpu_read_gnt: gnt=%b/%b addr=%h we=%b expected 1/0 010 0", cpu_gnt, dma_gnt, ram_addr, ram_we);
        end
        next_cycle();
        cpu_req = 0;
        #1;
        vectors++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || dma_rvalid !== 1'b0 || dma_rdata !== '0) begin
            miscompares++;
            $display("FAIL cpu_read_data: cpu %b/%h dma %b/%h expected 1/deadbeef 0/0", cpu_rvalid, cpu_rdata, dma_rvalid, dma_rdata);
        end
        next_cycle();
        #1;
        vectors++;
        if (cpu_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL cpu_read_once: cpu_rvalid=%b expected 0", cpu_rvalid);
        end
    endtask

    task automatic test_contention();
        do_reset();
        cpu_req = 1; cpu_addr = 11'h004; dma_req = 1; dma_addr = 11'h008;
        for (int c = 0; c < 17; c++) begin
            logic exp_d;
            exp_d = (c % 8) >= 4;
            #1;
            vectors++;
            if (dma_gnt !== exp_d || cpu_gnt !== !exp_d || cpu_stall !== exp_d) begin
                miscompares++;
                $display("FAIL contention c=%0d: cpu_gnt=%b dma_gnt=%b stall=%b expected %b %b %b",
                         c, cpu_gnt, dma_gnt, cpu_stall, !exp_d, exp_d, exp_d);
            end
            next_cycle();
        end
    endtask

    task automatic test_burst_last();
        do_reset();
        cpu_req = 1; cpu_addr = 11'h001; dma_req = 1; dma_addr = 11'h002;
        for (int c = 0; c < 11; c++) begin
            logic exp_d;
            dma_last = (c == 5);
            exp_d = (c == 4 || c == 5 || c == 10);
            #1;
            vectors++;
            if (dma_gnt !== exp_d || cpu_gnt !== !exp_d) begin
                miscompares++;
                $display("FAIL burst_last c=%0d: cpu_gnt=%b dma_gnt=%b expected %b %b", c, cpu_gnt, dma_gnt, !exp_d, exp_d);
            end
            if (c == 6) begin
                vectors++;
                if (dut.starve_cnt !== '0 || dut.state !== CPU_PRI) begin
                    miscompares++;
                    $display("FAIL burst_exit: starve=%0d state=%0d expected 0 0", dut.starve_cnt, dut.state);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_alternating();
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 11'h001;
        #1;
        vectors++;
        if (cpu_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL alt_cpu_gnt: got %b expected 1", cpu_gnt);
        end
        next_cycle();
        cpu_req = 0; dma_req = 1; dma_we = 0; dma_addr = 11'h002;
        #1;
        vectors++;
        if (dma_gnt !== 1'b1 || cpu_rvalid !== 1'b1 || cpu_rdata !== init_data[1] || dma_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL alt_cpu_resp: dma_gnt=%b cpu %b/%h dma_rvalid=%b expected 1 1/%h 0",
                     dma_gnt, cpu_rvalid, cpu_rdata, dma_rvalid, init_data[1]);
        end
        next_cycle();
        dma_req = 0;
        #1;
        vectors++;
        if (dma_rvalid !== 1'b1 || dma_rdata !== init_data[2] || cpu_rvalid !== 1'b0 || cpu_rdata !== '0) begin
            miscompares++;
            $display("FAIL alt_dma_resp: dma %b/%h cpu %b/%h expected 1/%h 0/0",
                     dma_rvalid, dma_rdata, cpu_rvalid, cpu_rdata, init_data[2]);
        end
        next_cycle();
    endtask

    task automatic test_dma_write();
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 11'h003;
        dma_req = 1; dma_we = 1; dma_addr = 11'h7FF; dma_wdata = 32'h12345678; dma_last = 1;
        for (int c = 0; c < 6; c++) begin
            logic exp_w;
            exp_w = (c == 4);
            #1;
            vectors++;
            if (ram_we !== exp_w || (exp_w && (ram_addr !== 11'h7FF || ram_wdata !== 32'h12345678 || cpu_stall !== 1'b1))) begin
                miscompares++;
                $display("FAIL dma_write c=%0d: we=%b addr=%h wdata=%h stall=%b expected we=%b",
                         c, ram_we, ram_addr, ram_wdata, cpu_stall, exp_w);
            end
            if (dma_gnt) begin
                next_cycle();
                dma_req = 0; dma_we = 0;
            end else begin
                next_cycle();
            end
        end
        cpu_req = 0;
        next_cycle();
        cpu_req = 1; cpu_addr = 11'h7FF;
        next_cycle();
        cpu_req = 0;
        #1;
        vectors++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h12345678) begin
            miscompares++;
            $display("FAIL dma_write_readback: %b/%h expected 1/12345678", cpu_rvalid, cpu_rdata);
        end
        next_cycle();
    endtask

    task automatic test_reset_inflight();
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 11'h005;
        next_cycle();
        rst = 1; cpu_addr = 11'h006; dma_req = 1;
        #1;
        vectors++;
        if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0 || cpu_gnt !== 1'b0 || dma_gnt !== 1'b0 || ram_we !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_inflight: rvalid %b/%b gnt %b/%b we=%b expected all 0",
                     cpu_rvalid, dma_rvalid, cpu_gnt, dma_gnt, ram_we);
        end
        next_cycle();
        rst = 0; dma_req = 0;
        #1;
        vectors++;
        if (cpu_rvalid !== 1'b0 || cpu_gnt !== 1'b1 || dut.state !== CPU_PRI || dut.starve_cnt !== '0 || dut.beat_cnt !== '0) begin
            miscompares++;
            $display("FAIL rst_after: rvalid=%b gnt=%b state=%0d starve=%0d beat=%0d expected 0 1 0 0 0",
                     cpu_rvalid, cpu_gnt, dut.state, dut.starve_cnt, dut.beat_cnt);
        end
        next_cycle();
        cpu_req = 0;
        #1;
        vectors++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== init_data[6]) begin
            miscompares++;
            $display("FAIL rst_first_read: %b/%h expected 1/%h", cpu_rvalid, cpu_rdata, init_data[6]);
        end
        next_cycle();
    endtask

    task automatic test_random();
        bit cpu_done = 1;
        bit dma_done = 1;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            int w;
            logic [AW-1:0] ea;
            logic [DW-1:0] ed;
            logic          ew;
            rst = ($urandom_range(0, 99) < 2);
            if (cpu_done || !cpu_req) begin
                cpu_req = ($urandom_range(0, 99) < 60);
                cpu_we = $urandom_range(0, 1);
                cpu_addr = ($urandom_range(0, 15) == 15) ? 11'h7FF : AW'($urandom_range(0, 14));
                cpu_wdata = $urandom;
            end
            if (dma_done || !dma_req) begin
                dma_req = ($urandom_range(0, 99) < 70);
                dma_we = $urandom_range(0, 1);
                dma_addr = AW'($urandom_range(0, 15));
                dma_wdata = $urandom;
                dma_last = ($urandom_range(0, 3) == 0);
            end
            #1;
            w = exp_winner();
            ea = (w == 1) ? cpu_addr : (w == 2) ? dma_addr : '0;
            ed = (w == 1) ? cpu_wdata : (w == 2) ? dma_wdata : '0;
            ew = (w == 1) ? cpu_we : (w == 2) ? dma_we : 1'b0;
            vectors++;
            if (cpu_gnt !== (w == 1) || dma_gnt !== (w == 2) || cpu_stall !== (cpu_req && w != 1)) begin
                miscompares++;
                $display("FAIL rnd_gnt c=%0d: cpu_gnt=%b dma_gnt=%b stall=%b expected winner %0d", c, cpu_gnt, dma_gnt, cpu_stall, w);
            end
            vectors++;
            if (ram_we !== ew || ram_addr !== ea || ram_wdata !== ed) begin
                miscompares++;
                $display("FAIL rnd_ram c=%0d: we=%b addr=%h wdata=%h expected %b %h %h", c, ram_we, ram_addr, ram_wdata, ew, ea, ed);
            end
            vectors++;
            if (cpu_rvalid !== (m_rv_owner == 1 && !rst) || dma_rvalid !== (m_rv_owner == 2 && !rst)
                || cpu_rdata !== ((m_rv_owner == 1 && !rst) ? m_rv_data : '0)
                || dma_rdata !== ((m_rv_owner == 2 && !rst) ? m_rv_data : '0)) begin
                miscompares++;
                $display("FAIL rnd_rd c=%0d: cpu %b/%h dma %b/%h expected owner %0d data %h",
                         c, cpu_rvalid, cpu_rdata, dma_rvalid, dma_rdata, rst ? 0 : m_rv_owner, m_rv_data);
            end
            cpu_done = (w == 1);
            dma_done = (w == 2);
            next_cycle();
        end
        rst = 0;
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            init_data[i] = $urandom;
            preload(AW'(i), init_data[i]);
        end
        preload(11'h7FF, 32'h0BADF00D);
        test_reset();
        test_cpu_read();
        test_contention();
        test_burst_last();
        test_alternating();
        test_dma_write();
        test_reset_inflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter sharing the single-ported data RAM (port 2) between the CPU load/store path and a DMA/loader engine. The CPU has default priority. A starvation counter forces bounded DMA bursts so the loader always progresses. The block sits between the CPU memory-stage signals (address, write enable, store data) and the RAM. It routes the synchronous read data back to whichever requester issued the read.

## Interface
- ADDR_W, 11, RAM word-address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive denied DMA cycles before DMA is forced (≥1)
- MAX_BURST, 4, maximum granted DMA beats per forced burst (≥1)

Ports:
- clk  in  1  clock; everything is rising-edge
- rst  in  1  reset, synchronous and active-high
- cpu_req  in  1  CPU access request
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_gnt  out  1  CPU access accepted this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDR_W/DATA_W  DMA request fields, same meaning as the CPU fields
- dma_last  in  1  current DMA beat ends the burst
- dma_gnt  out  1  DMA access accepted this cycle
- dma_rvalid  out  1  DMA read data valid
- dma_rdata  out  DATA_W  DMA read data
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after the address

## Operation
- FSM states: CPU_PRI (reset state) and DMA_BURST.
- Grant rules, evaluated combinationally each cycle; at most one grant per cycle:
  - CPU_PRI, starve_cnt < STARVE_LIMIT: cpu_req wins; otherwise dma_req wins (opportunistic, no burst).
  - CPU_PRI, starve_cnt == STARVE_LIMIT with dma_req: DMA wins over cpu_req.
    - Go to DMA_BURST unless dma_last=1 or MAX_BURST==1.
  - DMA_BURST: dma_req wins over cpu_req. If dma_req=0, the CPU may take the port that cycle.
- Leave DMA_BURST to CPU_PRI on any of:
  - a granted beat with dma_last=1;
  - dma_req=0;
  - the granted beat is number MAX_BURST of the burst, counting the entry beat.
- Counters:
  - starve_cnt increments when dma_req & ~dma_gnt and saturates at STARVE_LIMIT.
  - starve_cnt clears on any dma_gnt.
  - beat_cnt counts granted beats of a forced burst and clears on burst exit.
- RAM drive:
  - Driven from the winner's fields.
  - With no grant: ram_we=0, ram_addr=0, ram_wdata=0.
  - ram_we only ever equals winner_we & gnt.
- Read return:
  - A one-stage owner register records {rd_pending, rd_owner} for a granted read.
  - Next cycle, exactly one rvalid is asserted with rdata = ram_rdata.
  - The non-owner rdata is 0.
  - Writes produce no rvalid.
- Back-to-back reads from alternating requesters are legal. Each response goes to its own issuer.

## Timing
- Grant latency is 0 (same cycle as req). Read latency is 1 cycle after the grant. Write commits at the grant edge.
- The requester holds req and its fields until it sees gnt. Fields may change in the cycle after a grant.
- A request dropped before gnt is simply not served. No state is kept for it.
- Reset values: state=CPU_PRI, starve_cnt=0, beat_cnt=0, rd_pending=0, cpu_rvalid=dma_rvalid=0, rdata outputs 0.
- While rst=1: both gnt=0 and ram_we=0.
- Reset asserted with a read in flight: the response is dropped, and no rvalid appears in the following cycle.
- A dma_last beat coinciding with beat MAX_BURST gives a single exit. The next cycle is CPU_PRI with starve_cnt=0.
- Worst-case CPU stall is MAX_BURST cycles. Worst-case DMA wait is STARVE_LIMIT cycles.

## Structure
- Shared package: state enum (CPU_PRI, DMA_BURST), owner encoding (OWN_CPU=0, OWN_DMA=1), default STARVE_LIMIT/MAX_BURST constants.
- The read-return owner register is a natural sub-module, dmem_rd_return: it takes grant/owner/we and returns the per-requester rvalid/rdata.
- Counters and the FSM live in the top.

## Test plan
- CPU read at 0x010 only (RAM holds 0xDEADBEEF) -> cpu_gnt in cycle 0; cpu_rvalid with 0xDEADBEEF in cycle 1; dma_rvalid stays 0.
- cpu_req and dma_req held continuously -> CPU granted cycles 0–3; starve_cnt reaches 4; DMA granted cycles 4–7 (4 beats); CPU granted cycle 8; pattern repeats.
- Forced burst where dma_last is asserted on the 2nd beat -> exactly 2 DMA grants; CPU granted the next cycle; starve_cnt=0.
- Alternating reads CPU@0x001 then DMA@0x002 on idle cycles -> responses return in consecutive cycles, each only on its issuer's rvalid with the correct word.
- DMA write 0x12345678 to 0x7FF during a CPU stall -> ram_we=1 for exactly that cycle; a later CPU read of 0x7FF returns 0x12345678.
- rst=1 in the cycle after a granted read -> no rvalid; FSM in CPU_PRI; counters 0; first post-reset request granted normally.
